// File: rtl/apb_initiator_pkg.sv
// Shared types and constants for the APB initiator and its timeout counter.
package apb_initiator_pkg;

   localparam int unsigned APB_ADDR_W        = 32;
   localparam int unsigned APB_DATA_W        = 32;
   localparam logic [31:0] TIMEOUT_DATA_DEF  = 32'hDEAD_0A5B;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apbInitStateT;

   typedef struct packed {
      logic [APB_ADDR_W-1:0] addr;
      logic                  write;
      logic [APB_DATA_W-1:0] wdata;
   } apbInitReqSt;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apbInitRspSt;

endpackage

// File: rtl/apb_init_timeout.sv
// Saturating up-counter with clear/enable and a terminal-count flag at LIMIT-1.
// LIMIT of zero disables the flag entirely.
module apb_init_timeout #(
   parameter int unsigned LIMIT = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] TC = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (LIMIT != 0) && (cnt_q == TC);

endmodule

// File: rtl/apb_initiator.sv
// Single-outstanding APB3 requester: valid/ready request in, SETUP/ACCESS cycle out,
// valid/ready response back, with alignment check and bus-hang abort.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | psel high, penable low, one cycle
// ACCESS | psel and penable high until pready or timeout
// RESP   | rsp_valid high, fields held until rsp_ready
module apb_initiator
   import apb_initiator_pkg::*;
#(
   parameter int unsigned        ADDR_W         = 32,
   parameter int unsigned        DATA_W         = 32,
   parameter int unsigned        TIMEOUT_CYCLES = 256,
   parameter logic [DATA_W-1:0]  TIMEOUT_DATA   = DATA_W'(TIMEOUT_DATA_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_write,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   apbInitStateT      state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              pwrite_q, pwrite_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              tmo_clr, tmo_en, tmo_expired;

   // Clearing on every accept covers SETUP entry; misaligned requests never reach ACCESS.
   assign tmo_clr = (state_q == IDLE) && req_valid;
   assign tmo_en  = (state_q == ACCESS) && !pready;

   apb_init_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d       = state_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pwrite_d      = pwrite_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               paddr_d  = req_addr;
               pwrite_d = req_write;
               pwdata_d = req_wdata;
               if (req_addr[1:0] != 2'b00) begin
                  state_d       = RESP;
                  rsp_rdata_d   = TIMEOUT_DATA;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
               end else begin
                  state_d = SETUP;
                  psel_d  = 1'b1;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            // pready takes priority over a coincident timeout.
            if (pready) begin
               state_d       = RESP;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_rdata_d   = pwrite_q ? '0 : prdata;
               rsp_err_d     = pslverr;
               rsp_timeout_d = 1'b0;
            end else if (tmo_expired) begin
               state_d       = RESP;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_rdata_d   = TIMEOUT_DATA;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pwrite_q      <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pwrite_q      <= pwrite_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign req_ready   = (state_q == IDLE) && !rst;
   assign rsp_valid   = (state_q == RESP);
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Randomised bench for apb_initiator: per-transaction timeline model checked every cycle,
// plus directed transactions with literal latency/data expectations.
module tb_apb_initiator;

   localparam int          T  = 8;
   localparam logic [31:0] TD = 32'hDEAD_0A5B;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        req_write = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;

   apb_initiator #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (T),
      .TIMEOUT_DATA   (TD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_write   (req_write),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected per-cycle view, written by the stimulus process only.
   logic        e_req_ready = 1'b0, e_psel = 1'b0, e_pen = 1'b0, e_rv = 1'b0;
   logic [31:0] e_paddr = '0, e_pwdata = '0, e_rdata = '0;
   logic        e_pwrite = 1'b0, e_err = 1'b0, e_tmo = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         chk("req_ready", 64'(req_ready), 64'(e_req_ready));
         chk("psel",      64'(psel),      64'(e_psel));
         chk("penable",   64'(penable),   64'(e_pen));
         chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
         chk("paddr",     64'(paddr),     64'(e_paddr));
         chk("pwrite",    64'(pwrite),    64'(e_pwrite));
         chk("pwdata",    64'(pwdata),    64'(e_pwdata));
         if (e_rv) begin
            chk("rsp_rdata",   64'(rsp_rdata),   64'(e_rdata));
            chk("rsp_err",     64'(rsp_err),     64'(e_err));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(e_tmo));
         end
      end
   end

   // Observation of the last transaction, used only for literal expectations.
   int          a0 = 0, f_psel = -1, f_pen = -1, f_rv = -1, acc_cnt = 0;
   logic [31:0] cap_rdata = '0;
   logic        cap_err = 1'b0, cap_tmo = 1'b0;

   always @(negedge clk) begin
      if (req_valid && req_ready) begin
         a0 = cyc; f_psel = -1; f_pen = -1; f_rv = -1; acc_cnt = 0;
      end
      if (psel && f_psel < 0) f_psel = cyc;
      if (psel && penable) begin
         acc_cnt++;
         if (f_pen < 0) f_pen = cyc;
      end
      if (rsp_valid && f_rv < 0) f_rv = cyc;
      if (rsp_valid && rsp_ready) begin
         cap_rdata = rsp_rdata; cap_err = rsp_err; cap_tmo = rsp_timeout;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = 1'b0; req_addr = $urandom; req_write = 1'(($urandom)); req_wdata = $urandom;
         pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom); rsp_ready = 1'($urandom);
         e_req_ready = 1'b1; e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0;
         step();
      end
   endtask

   // w = wait states before pready; w >= T means the completer never answers.
   task automatic txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int w, input logic [31:0] rdat, input logic slv, input int rdelay);
      logic [31:0] r_d;
      logic        r_e, r_t;
      int          na;
      req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd;
      pready = 1'($urandom); rsp_ready = 1'($urandom);
      e_req_ready = 1'b1; e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0;
      step();
      req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom); req_wdata = $urandom;
      e_req_ready = 1'b0; e_paddr = addr; e_pwrite = wr; e_pwdata = wd;
      if (addr[1:0] != 2'b00) begin
         r_d = TD; r_e = 1'b1; r_t = 1'b0;
      end else begin
         e_psel = 1'b1; e_pen = 1'b0;
         pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
         step();
         na = (w < T) ? w + 1 : T;
         for (int j = 0; j < na; j++) begin
            e_pen   = 1'b1;
            pready  = (j == w);
            prdata  = (j == w) ? rdat : $urandom;
            pslverr = (j == w) ? slv : 1'($urandom);
            step();
         end
         e_psel = 1'b0; e_pen = 1'b0; pready = 1'($urandom);
         if (w < T) begin
            r_d = wr ? 32'h0 : rdat; r_e = slv; r_t = 1'b0;
         end else begin
            r_d = TD; r_e = 1'b1; r_t = 1'b1;
         end
      end
      e_rv = 1'b1; e_rdata = r_d; e_err = r_e; e_tmo = r_t;
      for (int k = 0; k < rdelay; k++) begin
         rsp_ready = 1'b0; pready = 1'($urandom);
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0; e_rv = 1'b0; e_req_ready = 1'b1;
   endtask

   task automatic reset_values_check(input string tag);
      chk({tag, "_rsp_rdata"},   64'(rsp_rdata),   64'h0);
      chk({tag, "_rsp_err"},     64'(rsp_err),     64'h0);
      chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'h0);
   endtask

   initial begin
      logic [31:0] a;
      // Power-on reset.
      step(); step();
      reset_values_check("por");
      step();
      rst = 1'b0; e_req_ready = 1'b1;
      idle(2);

      // Zero-wait read.
      txn(32'h100, 1'b0, 32'h0, 0, 32'h0000_000A, 1'b0, 0);
      chk("zw_psel_lat",  64'(f_psel - a0), 64'd1);
      chk("zw_pen_lat",   64'(f_pen - a0),  64'd2);
      chk("zw_rv_lat",    64'(f_rv - a0),   64'd3);
      chk("zw_rdata",     64'(cap_rdata),   64'h0000_000A);
      chk("zw_err",       64'(cap_err),     64'h0);

      // Write, three wait states.
      txn(32'hF8, 1'b1, 32'h7F, 3, 32'h1234_5678, 1'b0, 0);
      chk("ws_acc_cnt", 64'(acc_cnt),   64'd4);
      chk("ws_rv_lat",  64'(f_rv - a0), 64'd6);
      chk("ws_rdata",   64'(cap_rdata), 64'h0);
      chk("ws_err",     64'(cap_err),   64'h0);
      idle(1);

      // Completer error.
      txn(32'h1F0, 1'b0, 32'h0, 1, 32'hBADD_C0DE, 1'b1, 1);
      chk("se_err",   64'(cap_err),   64'h1);
      chk("se_tmo",   64'(cap_tmo),   64'h0);
      chk("se_rdata", 64'(cap_rdata), 64'hBADD_C0DE);

      // Timeout.
      txn(32'h40, 1'b0, 32'h0, 1000, 32'h0, 1'b0, 2);
      chk("to_acc_cnt", 64'(acc_cnt),   64'd8);
      chk("to_err",     64'(cap_err),   64'h1);
      chk("to_tmo",     64'(cap_tmo),   64'h1);
      chk("to_rdata",   64'(cap_rdata), 64'hDEAD_0A5B);

      // Last-chance pready on the cycle the timeout would fire.
      txn(32'h44, 1'b0, 32'h0, T - 1, 32'h5555_AAAA, 1'b0, 0);
      chk("edge_tmo",   64'(cap_tmo),   64'h0);
      chk("edge_rdata", 64'(cap_rdata), 64'h5555_AAAA);

      // Misaligned with backpressure.
      txn(32'h102, 1'b1, 32'hCAFE, 0, 32'h0, 1'b0, 5);
      chk("mis_psel_seen", 64'(f_psel), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("mis_rv_lat",    64'(f_rv - a0), 64'd1);
      chk("mis_err",       64'(cap_err),   64'h1);
      chk("mis_rdata",     64'(cap_rdata), 64'hDEAD_0A5B);
      idle(1);

      // Randomised traffic.
      for (int n = 0; n < 60; n++) begin
         a = $urandom;
         a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         txn(a, 1'($urandom), $urandom, int'($urandom_range(0, 11)), $urandom,
             1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
         idle(int'($urandom_range(0, 2)));
      end

      // Reset asserted between edges during ACCESS wait states.
      req_valid = 1'b1; req_addr = 32'h200; req_write = 1'b1; req_wdata = 32'h1111_2222;
      e_req_ready = 1'b1;
      step();
      req_valid = 1'b0; pready = 1'b0;
      e_req_ready = 1'b0; e_paddr = 32'h200; e_pwrite = 1'b1; e_pwdata = 32'h1111_2222; e_psel = 1'b1;
      step();
      e_pen = 1'b1;
      step();
      step();
      #1;
      rst = 1'b1;
      e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0; e_req_ready = 1'b0;
      e_paddr = '0; e_pwrite = 1'b0; e_pwdata = '0;
      #1;
      chk("rst_psel_async",    64'(psel),    64'h0);
      chk("rst_penable_async", 64'(penable), 64'h0);
      step();
      reset_values_check("mid");
      step();
      #2;
      rst = 1'b0; e_req_ready = 1'b1;
      step();
      idle(3);
      txn(32'h300, 1'b0, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 1);
      chk("post_rst_rdata", 64'(cap_rdata), 64'h0BAD_F00D);
      chk("post_rst_err",   64'(cap_err),   64'h0);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_initiator.md
Name: apb_initiator

Overview:
- Single-outstanding APB3 requester. Converts a valid/ready request channel (address, direction, write data) into a compliant SETUP/ACCESS bus cycle.
- Returns read data and error status on a valid/ready response channel.
- Drives the register-block APB completers in the design from a firmware/debug command path.
- Adds alignment checking and a bus-hang timeout so a dead completer cannot stall the requester.

Parameters:
ADDR_W, 32, paddr/req_addr width
DATA_W, 32, pwdata/prdata width (multiple of 8)
TIMEOUT_CYCLES, 256, max ACCESS cycles before abort; 0 disables the timeout
TIMEOUT_DATA, 32'hDEAD_0A5B, rsp_rdata value returned on timeout or misalignment

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_addr  in  ADDR_W  byte address
req_write  in  1  1=write, 0=read
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  pslverr, timeout or misalignment
rsp_timeout  out  1  error cause was timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  completer ready
pslverr  in  1  completer error

Behaviour:
- Reset (async assert, sync-safe deassert) forces the following:
  - state IDLE
  - psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0
  - paddr, pwdata, rsp_rdata = 0
  - timeout counter = 0
  - req_ready = 0 while rst is high
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1 combinationally; it is 1 only in IDLE.
  - On accept, capture addr/write/wdata into paddr/pwrite/pwdata.
  - If req_addr[1:0]!=0, go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=TIMEOUT_DATA, and no bus cycle.
  - Otherwise go to SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata remain stable.
  - When pready=1:
    - Reads: rsp_rdata=prdata.
    - Writes: rsp_rdata=0.
    - rsp_err=pslverr, rsp_timeout=0.
    - Drop psel/penable next cycle and go to RESP.
  - Timeout: the counter clears on SETUP entry and increments each ACCESS cycle with pready=0. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with pready=0:
    - Abort: psel/penable=0 next cycle.
    - rsp_err=1, rsp_timeout=1, rsp_rdata=TIMEOUT_DATA.
    - Go to RESP.
  - pready and the timeout in the same cycle: pready wins, giving a normal completion.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On handshake go to IDLE.
  - A new request can be accepted in the cycle after the response handshake. There is no same-cycle bypass.
- Latency with a zero-wait completer (accept at cycle 0):
  - psel=1 at cycle 1.
  - penable=1 and pready sampled at cycle 2.
  - rsp_valid at cycle 3.
  - Throughput is one transaction per 4 cycles at best; each wait state adds 1 cycle.
- Outside SETUP/ACCESS, paddr/pwrite/pwdata hold their last values. prdata and pslverr are sampled only when psel&penable&pready.
- Counter width is clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.
- Reset asserted mid-transaction drops psel/penable immediately, without waiting for a clock. The in-flight transaction is discarded and no response is produced.
- Inputs are held don't-care outside their valid window. pready outside ACCESS is ignored.

Decomposition:
- Shared package apb_initiator_pkg holds:
  - the state enum apbInitStateT {IDLE, SETUP, ACCESS, RESP}
  - the request struct apbInitReqSt {addr, write, wdata}
  - the response struct apbInitRspSt {rdata, err, timeout}
  - the default TIMEOUT_DATA constant
- One sub-module, apb_init_timeout, is natural: a parameterised saturating counter with clear/enable/expired outputs, reusable by other bus masters.
- The FSM and datapath stay in apb_initiator.

Test Plan:
- Zero-wait read:
  - Stimulus: req addr=0x100, write=0; completer prdata=0x0000_000A, pready=1 in ACCESS.
  - Required: psel at cycle 1, penable at cycle 2, rsp_valid at cycle 3; rsp_rdata=0x0000_000A, rsp_err=0.
- Write with 3 wait states:
  - Stimulus: addr=0xF8, wdata=0x7F.
  - Required: paddr/pwdata/pwrite stable for all 4 ACCESS cycles; rsp_valid at cycle 6; rsp_rdata=0, rsp_err=0.
- Completer error:
  - Stimulus: read addr=0x1F0; completer pslverr=1, prdata=0xBADD_C0DE.
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0xBADD_C0DE.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, pready stuck 0.
  - Required: exactly 8 ACCESS cycles, then psel=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0xDEAD_0A5B.
- Misaligned request and backpressure:
  - Stimulus: req addr=0x102; hold rsp_ready=0 for 5 cycles.
  - Required: psel never asserts; rsp fields stable for all 5 cycles; req_ready=0 throughout; IDLE on the cycle after the handshake.
- Reset mid-ACCESS:
  - Stimulus: assert rst between clock edges during wait states.
  - Required: psel/penable fall without a clock edge; no rsp_valid after release; the next request completes normally.
